intt_ctrl: RTL and testbench

//   Sequencer for the inverse-NTT butterfly unit (Gentleman-Sande, A+B / W*(B-A)) over one 256-coeff ML-KEM poly.

---
 rtl/intt_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_intt_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intt_ctrl.sv
// ---------------------------------------------------------------------------
// intt_ctrl
//   Address/strobe sequencer for an inverse-NTT (Gentleman-Sande) butterfly
//   unit working on one 256-coefficient ML-KEM polynomial held in a
//   dual-port coefficient RAM. Runs 7 layers (len = 2 .. 128), 128 butterflies
//   per layer, one butterfly issued per cycle. Each issue pushes a write tag
//   into an L = RD_LAT + BU_LAT deep shift register so the write addresses
//   and enables emerge exactly when the butterfly results do. Between layers
//   the sequencer drains for L cycles so no read of layer n+1 overtakes a
//   write of layer n. Coefficient data never passes through this block.
//
//   Optional feature macro: INTT_SCALE_EN
//     defined   : after the last layer a SCALE pass issues 256 ops that
//                 multiply every coefficient by the scale constant stored at
//                 twiddle ROM index SCALE_IDX (A input forced to 0).
//     undefined : no scale pass, zero_a tied low, scaling is done downstream.
//
// Parameters
//   RD_LAT     read latency, addresses to data at butterfly inputs
//   BU_LAT     butterfly input-to-output latency
//   SCALE_IDX  twiddle ROM index of the scale constant (INTT_SCALE_EN only)
//   RD_LAT + BU_LAT must be at least 2.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  start pulse, only honoured in IDLE
//   busy       out  1  run in progress
//   done       out  1  one-cycle pulse once all writes have retired
//   rd_en      out  1  butterfly issue strobe
//   rd_addr_a  out  8  RAM address of A operand (j)
//   rd_addr_b  out  8  RAM address of B operand (j + len)
//   tw_addr    out  8  twiddle ROM address, valid with rd_en
//   zero_a     out  1  force butterfly A input to zero (scale pass)
//   wr_en_a    out  1  write A result
//   wr_en_b    out  1  write B result
//   wr_addr_a  out  8  write address for A result
//   wr_addr_b  out  8  write address for B result
// ---------------------------------------------------------------------------
module intt_ctrl #(
  parameter int RD_LAT = 1,
  parameter int BU_LAT = 22
`ifdef INTT_SCALE_EN
  , parameter int SCALE_IDX = 128
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [7:0] tw_addr,
  output logic       zero_a,
  output logic       wr_en_a,
  output logic       wr_en_b,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam int L    = RD_LAT + BU_LAT;
  localparam int DCW  = (L > 1) ? $clog2(L) : 1;
  localparam int TAGW = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
`ifdef INTT_SCALE_EN
    S_SCALE,
`endif
    S_FIN
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [2:0]       layer;
  logic [7:0]       n;
  logic [6:0]       k;
  logic [DCW-1:0]   drain_cnt;
`ifdef INTT_SCALE_EN
  logic             scale_pass;
`endif

  logic [3:0]       s;
  logic [7:0]       len;
  logic [7:0]       mask;
  logic [7:0]       bf_a;
  logic [7:0]       bf_b;
  logic             group_end;
  logic             issue_last;
  logic             drain_last;
  logic             last_layer;

  logic [TAGW-1:0]        tag;
  logic [L-1:0][TAGW-1:0] tag_pipe;

  // Butterfly address generation. For a layer with half-span len = 2^s the
  // n-th butterfly of the layer touches j and j+len, where j is n with a
  // zero bit inserted at position s (group index shifted up past the pair).
  always_comb begin
    s          = {1'b0, layer} + 4'd1;
    len        = 8'd2 << layer;
    mask       = len - 8'd1;
    bf_a       = ((n >> s) << (s + 4'd1)) | (n & mask);
    bf_b       = bf_a + len;
    group_end  = (n & mask) == mask;
    issue_last = n == 8'd127;
    drain_last = drain_cnt == DCW'(L - 1);
    last_layer = layer == 3'd6;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Every issue phase is followed by a full-latency drain
  // so the following phase never reads a coefficient still in flight.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (issue_last) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) begin
          if (!last_layer) begin
            next_state = S_ISSUE;
          end else begin
`ifdef INTT_SCALE_EN
            next_state = scale_pass ? S_FIN : S_SCALE;
`else
            next_state = S_FIN;
`endif
          end
        end
      end
`ifdef INTT_SCALE_EN
      S_SCALE: begin
        if (n == 8'd255) next_state = S_DRAIN;
      end
`endif
      S_FIN: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Layer, butterfly, twiddle and drain counters. The twiddle index k walks
  // down from 127 and steps once per butterfly group, so it reaches 0 right
  // after the single group of the last layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer      <= 3'd0;
      n          <= 8'd0;
      k          <= 7'd0;
      drain_cnt  <= '0;
`ifdef INTT_SCALE_EN
      scale_pass <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            layer      <= 3'd0;
            n          <= 8'd0;
            k          <= 7'd127;
            drain_cnt  <= '0;
`ifdef INTT_SCALE_EN
            scale_pass <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          n <= issue_last ? 8'd0 : n + 8'd1;
          if (group_end) k <= k - 7'd1;
        end
        S_DRAIN: begin
          if (drain_last) begin
            drain_cnt <= '0;
            if (!last_layer) begin
              layer <= layer + 3'd1;
            end else begin
`ifdef INTT_SCALE_EN
              scale_pass <= 1'b1;
`endif
            end
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
`ifdef INTT_SCALE_EN
        S_SCALE: begin
          n <= n + 8'd1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Issue-side outputs and the write tag {wa, wb, ena, enb} pushed into the
  // latency pipeline. Everything is forced low outside the issuing states.
  always_comb begin
    busy      = state != S_IDLE;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr_a = 8'd0;
    rd_addr_b = 8'd0;
    tw_addr   = 8'd0;
    zero_a    = 1'b0;
    tag       = '0;
    case (state)
      S_ISSUE: begin
        rd_en     = 1'b1;
        rd_addr_a = bf_a;
        rd_addr_b = bf_b;
        tw_addr   = {1'b0, k};
        tag       = {bf_a, bf_b, 2'b11};
      end
`ifdef INTT_SCALE_EN
      S_SCALE: begin
        rd_en     = 1'b1;
        rd_addr_b = n;
        tw_addr   = 8'(SCALE_IDX);
        zero_a    = 1'b1;
        tag       = {8'd0, n, 2'b01};
      end
`endif
      S_FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write-tag delay line. A reset clears every stage so in-flight writes of
  // an aborted run are dropped immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe <= {tag_pipe[L-2:0], tag};
    end
  end

  assign wr_addr_a = tag_pipe[L-1][17:10];
  assign wr_addr_b = tag_pipe[L-1][9:2];
  assign wr_en_a   = tag_pipe[L-1][1];
  assign wr_en_b   = tag_pipe[L-1][0];

endmodule

// File: tb/tb_intt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intt_ctrl
//   Self-checking bench for intt_ctrl with default parameters (L = 23).
//   A table of hand-computed vectors is checked at specific cycles of a run,
//   and a reference model built from the textbook inverse-NTT loop nest
//   checks every cycle of the run. Also covers reset state, reset abort and
//   start pulses while busy / coincident with done.
// ---------------------------------------------------------------------------
module tb_intt_ctrl;

  localparam int LAT  = 23;
  localparam int NCYC = 1400;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [7:0] tw_addr;
  logic       zero_a;
  logic       wr_en_a;
  logic       wr_en_b;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;

  intt_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .zero_a    (zero_a),
    .wr_en_a   (wr_en_a),
    .wr_en_b   (wr_en_b),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         start;
    bit         rd_en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tw;
    bit         zero;
    bit         wea;
    bit         web;
    logic [7:0] wa;
    logic [7:0] wb;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t       vecs[$];

  bit         m_rd   [NCYC];
  logic [7:0] m_a    [NCYC];
  logic [7:0] m_b    [NCYC];
  logic [7:0] m_tw   [NCYC];
  bit         m_zero [NCYC];
  bit         m_wea  [NCYC];
  bit         m_web  [NCYC];
  logic [7:0] m_wa   [NCYC];
  logic [7:0] m_wb   [NCYC];
  int         done_cyc;

  int cur;
  int seq_err;
  int first_bad;
  int tests_run;
  int tests_failed;

  function automatic vec_t mk(input int cyc, input bit st, input bit rd,
                              input int a, input int b, input int tw,
                              input bit z, input bit wea, input bit web,
                              input int wa, input int wb,
                              input bit bsy, input bit dn);
    vec_t v;
    v.cyc   = cyc;
    v.start = st;
    v.rd_en = rd;
    v.a     = 8'(a);
    v.b     = 8'(b);
    v.tw    = 8'(tw);
    v.zero  = z;
    v.wea   = wea;
    v.web   = web;
    v.wa    = 8'(wa);
    v.wb    = 8'(wb);
    v.busy  = bsy;
    v.done  = dn;
    return v;
  endfunction

  // Reference schedule from the plain inverse-NTT loop nest: one butterfly
  // per cycle from cycle 1, a LAT-cycle gap after each layer, writes LAT
  // cycles after their reads.
  task automatic build_model();
    int c;
    int kk;
    int ln;
    for (int i = 0; i < NCYC; i++) begin
      m_rd[i] = 1'b0; m_a[i] = 8'd0; m_b[i] = 8'd0; m_tw[i] = 8'd0;
      m_zero[i] = 1'b0; m_wea[i] = 1'b0; m_web[i] = 1'b0;
      m_wa[i] = 8'd0; m_wb[i] = 8'd0;
    end
    c  = 1;
    kk = 127;
    for (int lay = 0; lay < 7; lay++) begin
      ln = 2 << lay;
      for (int st = 0; st < 256; st += 2 * ln) begin
        for (int j = st; j < st + ln; j++) begin
          m_rd[c] = 1'b1;
          m_a[c]  = 8'(j);
          m_b[c]  = 8'(j + ln);
          m_tw[c] = 8'(kk);
          m_wea[c + LAT] = 1'b1;
          m_web[c + LAT] = 1'b1;
          m_wa[c + LAT]  = 8'(j);
          m_wb[c + LAT]  = 8'(j + ln);
          c++;
        end
        kk--;
      end
      c += LAT;
    end
`ifdef INTT_SCALE_EN
    for (int i = 0; i < 256; i++) begin
      m_rd[c]   = 1'b1;
      m_a[c]    = 8'd0;
      m_b[c]    = 8'(i);
      m_tw[c]   = 8'd128;
      m_zero[c] = 1'b1;
      m_web[c + LAT] = 1'b1;
      m_wb[c + LAT]  = 8'(i);
      c++;
    end
    c += LAT;
`endif
    done_cyc = c;
  endtask

  function automatic bit model_ok(input int c);
    bit ok;
    ok = 1'b1;
    if (rd_en !== m_rd[c] || zero_a !== m_zero[c]) ok = 1'b0;
    if (m_rd[c] && (rd_addr_a !== m_a[c] || rd_addr_b !== m_b[c] ||
                    tw_addr !== m_tw[c])) ok = 1'b0;
    if (wr_en_a !== m_wea[c] || wr_en_b !== m_web[c]) ok = 1'b0;
    if (m_wea[c] && wr_addr_a !== m_wa[c]) ok = 1'b0;
    if (m_web[c] && wr_addr_b !== m_wb[c]) ok = 1'b0;
    if (busy !== (c >= 1 && c <= done_cyc)) ok = 1'b0;
    if (done !== (c == done_cyc)) ok = 1'b0;
    return ok;
  endfunction

  // Advance one cycle; sample at the falling edge, clear start.
  task automatic step();
    @(negedge clk);
    cur++;
    start = 1'b0;
    if (!model_ok(cur)) begin
      seq_err++;
      if (first_bad < 0) first_bad = cur;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit use_start);
    if (use_start && v.start) start = 1'b1;
  endtask

  task automatic checkOutput(input vec_t v);
    bit bad;
    bad = 1'b0;
    if (rd_en !== v.rd_en || zero_a !== v.zero) bad = 1'b1;
    if (v.rd_en && (rd_addr_a !== v.a || rd_addr_b !== v.b || tw_addr !== v.tw)) bad = 1'b1;
    if (wr_en_a !== v.wea || wr_en_b !== v.web) bad = 1'b1;
    if (v.wea && wr_addr_a !== v.wa) bad = 1'b1;
    if (v.web && wr_addr_b !== v.wb) bad = 1'b1;
    if (busy !== v.busy || done !== v.done) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("[TB] FAIL vec_c%0d got rd=%b a=%0d b=%0d tw=%0d z=%b wea=%b web=%b wa=%0d wb=%0d busy=%b done=%b required rd=%b a=%0d b=%0d tw=%0d z=%b wea=%b web=%b wa=%0d wb=%0d busy=%b done=%b",
               v.cyc, rd_en, rd_addr_a, rd_addr_b, tw_addr, zero_a, wr_en_a, wr_en_b,
               wr_addr_a, wr_addr_b, busy, done,
               v.rd_en, v.a, v.b, v.tw, v.zero, v.wea, v.web, v.wa, v.wb, v.busy, v.done);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s got %b required %b", name, actual, required);
    end
  endtask

  task automatic check_all_low(input string name);
    logic [45:0] outs;
    outs = {busy, done, rd_en, zero_a, wr_en_a, wr_en_b,
            rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("[TB] FAIL %s got outputs=%h required 0", name, outs);
    end
  endtask

  // One full run from a start pulse at cycle 0 (current falling edge).
  task automatic run_sequence(input bit use_start, input string name);
    seq_err   = 0;
    first_bad = -1;
    cur       = 0;
    start     = 1'b1;
    foreach (vecs[i]) begin
      while (cur < vecs[i].cyc) step();
      applyStimulus(vecs[i], use_start);
      checkOutput(vecs[i]);
    end
    while (cur < done_cyc + 2) step();
    tests_run++;
    if (seq_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_sequence got %0d cycles off the model (first at cycle %0d) required 0",
               name, seq_err, first_bad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int activity;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    build_model();

    // Hand-computed vectors (L = 23, layer k starts at cycle 1 + 151*k).
    vecs.push_back(mk(   1, 0, 1,   0,   2, 127, 0, 0, 0,   0,   0, 1, 0));
    vecs.push_back(mk(   2, 0, 1,   1,   3, 127, 0, 0, 0,   0,   0, 1, 0));
    vecs.push_back(mk(   3, 0, 1,   4,   6, 126, 0, 0, 0,   0,   0, 1, 0));
    vecs.push_back(mk(  23, 0, 1,  44,  46, 116, 0, 0, 0,   0,   0, 1, 0));
    vecs.push_back(mk(  24, 0, 1,  45,  47, 116, 0, 1, 1,   0,   2, 1, 0));
    vecs.push_back(mk(  50, 1, 1,  97,  99, 103, 0, 1, 1,  52,  54, 1, 0));
    vecs.push_back(mk( 128, 0, 1, 253, 255,  64, 0, 1, 1, 208, 210, 1, 0));
    vecs.push_back(mk( 129, 0, 0,   0,   0,   0, 0, 1, 1, 209, 211, 1, 0));
    vecs.push_back(mk( 151, 0, 0,   0,   0,   0, 0, 1, 1, 253, 255, 1, 0));
    vecs.push_back(mk( 152, 0, 1,   0,   4,  63, 0, 0, 0,   0,   0, 1, 0));
    vecs.push_back(mk( 308, 0, 1,   5,  13,  31, 0, 0, 0,   0,   0, 1, 0));
    vecs.push_back(mk( 600, 1, 0,   0,   0,   0, 0, 1, 1, 235, 251, 1, 0));
    vecs.push_back(mk( 907, 0, 1,   0, 128,   1, 0, 0, 0,   0,   0, 1, 0));
    vecs.push_back(mk(1034, 0, 1, 127, 255,   1, 0, 1, 1, 104, 232, 1, 0));
    vecs.push_back(mk(1057, 0, 0,   0,   0,   0, 0, 1, 1, 127, 255, 1, 0));
`ifdef INTT_SCALE_EN
    vecs.push_back(mk(1058, 0, 1,   0,   0, 128, 1, 0, 0,   0,   0, 1, 0));
    vecs.push_back(mk(1081, 0, 1,   0,  23, 128, 1, 0, 1,   0,   0, 1, 0));
    vecs.push_back(mk(1313, 0, 1,   0, 255, 128, 1, 0, 1,   0, 232, 1, 0));
    vecs.push_back(mk(1336, 0, 0,   0,   0,   0, 0, 0, 1,   0, 255, 1, 0));
    vecs.push_back(mk(1337, 1, 0,   0,   0,   0, 0, 0, 0,   0,   0, 1, 1));
    vecs.push_back(mk(1338, 0, 0,   0,   0,   0, 0, 0, 0,   0,   0, 0, 0));
`else
    vecs.push_back(mk(1058, 1, 0,   0,   0,   0, 0, 0, 0,   0,   0, 1, 1));
    vecs.push_back(mk(1059, 0, 0,   0,   0,   0, 0, 0, 0,   0,   0, 0, 0));
`endif

    // Reset state, then idle after release.
    repeat (2) @(negedge clk);
    check_all_low("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_low("idle_after_reset");

    // Plain run.
    run_sequence(1'b0, "plain");

    // Reset abort during layer 3 issue (cycles 454..581).
    seq_err   = 0;
    first_bad = -1;
    cur       = 0;
    start     = 1'b1;
    while (cur < 500) step();
    tests_run++;
    if (seq_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_prefix got %0d cycles off the model (first at cycle %0d) required 0",
               seq_err, first_bad);
    end
    check_bit("abort_pre_active", rd_en & wr_en_a & wr_en_b & busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_low("abort_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    activity = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || done || rd_en || wr_en_a || wr_en_b) activity++;
    end
    tests_run++;
    if (activity != 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_quiet got %0d active cycles required 0", activity);
    end

    // Restart after abort, with start pulses while busy and at done.
    run_sequence(1'b1, "restart");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
